// File: rtl/mul_secp256k1_field_iter.sv
// mul_secp256k1_field_iter
//   Iterative unsigned multiplier that feeds the secp256k1 modular reducer.
//   It takes two p-bit field elements and produces their full 2p-bit product.
//   One LIMB-wide slice of b is consumed per cycle, so a product takes N = p/LIMB cycles.
//
// Ports
//   clk     in   1     rising-edge clock
//   areset  in   1     asynchronous reset, active-high
//   ival    in   1     operands valid
//   irdy    out  1     operands can be accepted (combinational from ordy while DONE)
//   a, b    in   p     multiplicand / multiplier, unsigned
//   oval    out  1     product valid (registered)
//   ordy    in   1     downstream ready
//   c       out  2p    product a*b (accumulator register, meaningful while oval)
module mul_secp256k1_field_iter #(
    parameter int unsigned p    = 256,
    parameter int unsigned LIMB = 64
) (
    input  logic           clk,
    input  logic           areset,
    input  logic           ival,
    output logic           irdy,
    input  logic [p-1:0]   a,
    input  logic [p-1:0]   b,
    output logic           oval,
    input  logic           ordy,
    output logic [2*p-1:0] c
);

    localparam int unsigned N     = p / LIMB;
    localparam int unsigned W2    = 2 * p;
    localparam int unsigned PPW   = p + LIMB;
    localparam int unsigned CNT_W = (N > 1) ? $clog2(N) : 1;

    // Operand width must split into whole limbs.
    generate
        if ((p % LIMB) != 0) begin : g_bad_limb
            $error("mul_secp256k1_field_iter: p must be a multiple of LIMB");
        end
    endgenerate

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_BUSY = 2'd1,
        S_DONE = 2'd2
    } state_t;

    state_t           state_q;
    logic [CNT_W-1:0] cnt_q;
    logic [p-1:0]     a_q;
    logic [p-1:0]     b_q;
    logic [W2-1:0]    acc_q;
    logic [W2-1:0]    acc_d;
    logic             oval_q;
    logic [LIMB-1:0]  limb_c;
    logic [PPW-1:0]   pp_c;
    logic             last_c;

    // Partial product of a with the current limb of b, aligned to the limb position.
    always_comb begin
        limb_c = b_q[LIMB*cnt_q +: LIMB];
        pp_c   = PPW'(a_q) * PPW'(limb_c);
        acc_d  = acc_q + (W2'(pp_c) << (LIMB * cnt_q));
        last_c = (cnt_q == CNT_W'(N - 1));
    end

    // Accept while idle, or while the held result is leaving on this same edge.
    assign irdy = (state_q == S_IDLE) | ((state_q == S_DONE) & ordy);
    assign oval = oval_q;
    assign c    = acc_q;

    // Control FSM and datapath registers.
    always_ff @(posedge clk or posedge areset) begin
        if (areset) begin
            state_q <= S_IDLE;
            cnt_q   <= '0;
            acc_q   <= '0;
            oval_q  <= 1'b0;
            a_q     <= '0;
            b_q     <= '0;
        end else begin
            case (state_q)
                S_IDLE: begin
                    if (ival) begin
                        a_q     <= a;
                        b_q     <= b;
                        acc_q   <= '0;
                        cnt_q   <= '0;
                        state_q <= S_BUSY;
                    end
                end
                S_BUSY: begin
                    acc_q <= acc_d;
                    if (last_c) begin
                        cnt_q   <= '0;
                        oval_q  <= 1'b1;
                        state_q <= S_DONE;
                    end else begin
                        cnt_q <= cnt_q + CNT_W'(1);
                    end
                end
                S_DONE: begin
                    if (ordy) begin
                        oval_q <= 1'b0;
                        if (ival) begin
                            a_q     <= a;
                            b_q     <= b;
                            acc_q   <= '0;
                            cnt_q   <= '0;
                            state_q <= S_BUSY;
                        end else begin
                            state_q <= S_IDLE;
                        end
                    end
                end
                default: begin
                    state_q <= S_IDLE;
                    oval_q  <= 1'b0;
                end
            endcase
        end
    end

endmodule
